blink_sequencer: RTL and testbench



---
 rtl/blink_seq_pkg.sv | 33 +++
 rtl/blink_prescaler.sv | 39 +++
 rtl/blink_sequencer.sv | 139 +++++++++++++
 tb/tb_blink_sequencer.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/blink_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : blink_seq_pkg
//  Description : Shared types and helpers for the LED blink sequencer:
//                FSM state encoding, pattern table entry layout and the
//                table index width helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package blink_seq_pkg;

    // Default duration field width; the entry layout below is built on it,
    // so the top-level DUR_W must stay equal to this value.
    localparam int c_dur_w = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        COUNT = 2'd2
    } state_t;

    typedef struct packed {
        logic               led;
        logic [c_dur_w-1:0] dur;
        logic               last;
    } entry_t;

    // Width of a table index for a table of n entries.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage : blink_seq_pkg
`default_nettype wire

// File: rtl/blink_prescaler.sv
`default_nettype none
// ============================================================================
//  Module      : blink_prescaler
//  Description : Free-running 0..PRESCALE-1 counter with synchronous clear
//                and enable; emits a one-cycle tick on the terminal count.
//  Revision    : 1.0 - initial release
// ============================================================================
module blink_prescaler #(
    parameter int PRESCALE = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tick
);

    localparam int c_cnt_w = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(PRESCALE - 1);

    logic [c_cnt_w-1:0] r_cnt;

    // Count while enabled, wrapping at the terminal value; clear has priority.
    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            if (r_cnt == c_last) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_tick = i_en && (r_cnt == c_last);

endmodule : blink_prescaler
`default_nettype wire

// File: rtl/blink_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : blink_sequencer
//  Description : Plays a programmable LED on/off pattern from a small flop
//                table, once or looping, with busy/done status.
//  Revision    : 1.0 - initial release
// ============================================================================
module blink_sequencer
    import blink_seq_pkg::*;
#(
    parameter int STEPS    = 8,
    parameter int DUR_W    = c_dur_w,
    parameter int PRESCALE = 1000
) (
    input  logic                          system1000,
    input  logic                          system1000_rst,
    input  logic                          cfg_we,
    input  logic [idx_width(STEPS)-1:0]   cfg_addr,
    input  logic                          cfg_led,
    input  logic [DUR_W-1:0]              cfg_dur,
    input  logic                          cfg_last,
    input  logic                          start,
    input  logic                          stop,
    input  logic                          loop,
    output logic                          busy,
    output logic                          done,
    output logic                          led_o,
    output logic [idx_width(STEPS)-1:0]   step_o
);

    localparam int c_idx_w = idx_width(STEPS);
    localparam logic [c_idx_w-1:0] c_last_step = c_idx_w'(STEPS - 1);

    entry_t             r_table [STEPS];
    state_t             r_state;
    logic [c_idx_w-1:0] r_step;
    logic [DUR_W-1:0]   r_remaining;
    logic               r_loop;
    logic               r_last;
    logic               r_busy;
    logic               r_done;
    logic               r_led;

    logic               w_tick;
    logic [DUR_W-1:0]   w_dur;
    logic [DUR_W-1:0]   w_dur_eff;

    // A zero duration would otherwise underflow the remaining counter.
    assign w_dur     = r_table[r_step].dur;
    assign w_dur_eff = (w_dur == '0) ? DUR_W'(1) : w_dur;

    // Prescaler only runs while an entry is being timed; FETCH restarts it.
    blink_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk    (system1000),
        .rst    (system1000_rst),
        .i_clr  (r_state != COUNT),
        .i_en   (r_state == COUNT),
        .o_tick (w_tick)
    );

    // Pattern table: writable only while idle, contents survive reset.
    always_ff @(posedge system1000) begin
        if (cfg_we && !r_busy) begin
            r_table[cfg_addr] <= '{led: cfg_led, dur: cfg_dur, last: cfg_last};
        end
    end

    // Playback FSM with registered outputs; stop overrides every transition.
    always_ff @(posedge system1000) begin
        if (system1000_rst) begin
            r_state     <= IDLE;
            r_step      <= '0;
            r_remaining <= '0;
            r_loop      <= 1'b0;
            r_last      <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_led       <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (stop) begin
                r_state <= IDLE;
                r_led   <= 1'b0;
                r_busy  <= 1'b0;
                r_step  <= '0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (start) begin
                            r_state <= FETCH;
                            r_step  <= '0;
                            r_busy  <= 1'b1;
                            r_loop  <= loop;
                        end
                    end
                    FETCH: begin
                        r_led       <= r_table[r_step].led;
                        r_remaining <= w_dur_eff;
                        r_last      <= r_table[r_step].last;
                        r_state     <= COUNT;
                    end
                    COUNT: begin
                        if (w_tick) begin
                            r_remaining <= r_remaining - 1'b1;
                            if (r_remaining == DUR_W'(1)) begin
                                if (r_last || (r_step == c_last_step)) begin
                                    if (r_loop) begin
                                        r_state <= FETCH;
                                        r_step  <= '0;
                                    end else begin
                                        r_state <= IDLE;
                                        r_led   <= 1'b0;
                                        r_busy  <= 1'b0;
                                        r_done  <= 1'b1;
                                    end
                                end else begin
                                    r_state <= FETCH;
                                    r_step  <= r_step + 1'b1;
                                end
                            end
                        end
                    end
                    default: begin
                        r_state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign busy   = r_busy;
    assign done   = r_done;
    assign led_o  = r_led;
    assign step_o = r_step;

endmodule : blink_sequencer
`default_nettype wire

// File: tb/tb_blink_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_blink_sequencer
//  Description : Directed self-checking bench for blink_sequencer with
//                PRESCALE=4, STEPS=8, DUR_W=8.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_blink_sequencer;

    logic       clk;
    logic       rst;
    logic       cfg_we;
    logic [2:0] cfg_addr;
    logic       cfg_led;
    logic [7:0] cfg_dur;
    logic       cfg_last;
    logic       start;
    logic       stop;
    logic       loop;
    logic       busy;
    logic       done;
    logic       led_o;
    logic [2:0] step_o;

    int n_checks = 0;
    int n_errors = 0;

    blink_sequencer #(
        .STEPS    (8),
        .DUR_W    (8),
        .PRESCALE (4)
    ) dut (
        .system1000     (clk),
        .system1000_rst (rst),
        .cfg_we         (cfg_we),
        .cfg_addr       (cfg_addr),
        .cfg_led        (cfg_led),
        .cfg_dur        (cfg_dur),
        .cfg_last       (cfg_last),
        .start          (start),
        .stop           (stop),
        .loop           (loop),
        .busy           (busy),
        .done           (done),
        .led_o          (led_o),
        .step_o         (step_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int actual, input int expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    task automatic write_entry(input logic [2:0] a, input logic l, input logic [7:0] d, input logic t);
        cfg_we   = 1'b1;
        cfg_addr = a;
        cfg_led  = l;
        cfg_dur  = d;
        cfg_last = t;
        @(negedge clk);
        cfg_we   = 1'b0;
    endtask

    // Pulse start, then observe a fixed window; optional table write mid-run.
    task automatic run_play(input logic l, input int window,
                            input logic do_wr, input int wr_at,
                            input logic [2:0] wa, input logic wl,
                            input logic [7:0] wd, input logic wlast,
                            output int n_busy, output int n_led,
                            output int n_done, output int max_step,
                            output int first_led);
        n_busy = 0; n_led = 0; n_done = 0; max_step = 0; first_led = -1;
        start = 1'b1;
        loop  = l;
        @(negedge clk);
        start = 1'b0;
        loop  = 1'b0;
        for (int c = 0; c < window; c++) begin
            if (busy)  n_busy++;
            if (done)  n_done++;
            if (led_o) begin
                n_led++;
                if (first_led < 0) first_led = c;
            end
            if (int'(step_o) > max_step) max_step = int'(step_o);
            if (do_wr && c == wr_at) begin
                cfg_we   = 1'b1;
                cfg_addr = wa;
                cfg_led  = wl;
                cfg_dur  = wd;
                cfg_last = wlast;
            end else begin
                cfg_we = 1'b0;
            end
            @(negedge clk);
        end
        cfg_we = 1'b0;
    endtask

    int nb, nl, nd, ms, fl;

    initial begin
        rst = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_led = 1'b0;
        cfg_dur = '0; cfg_last = 1'b0; start = 1'b0; stop = 1'b0; loop = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_led", led_o, 0);
        check("rst_step", step_o, 0);

        // Two-entry pattern, single shot
        write_entry(3'd0, 1'b1, 8'd2, 1'b0);
        write_entry(3'd1, 1'b0, 8'd3, 1'b1);
        run_play(1'b0, 30, 1'b0, 0, 3'd0, 1'b0, 8'd0, 1'b0, nb, nl, nd, ms, fl);
        check("once_busy_cycles", nb, 22);
        check("once_led_cycles", nl, 9);
        check("once_done_pulses", nd, 1);
        check("once_first_led", fl, 1);
        check("once_max_step", ms, 1);

        // Looping pattern, then stop mid-e1
        start = 1'b1; loop = 1'b1;
        @(negedge clk);
        start = 1'b0; loop = 1'b0;
        nd = 0;
        for (int c = 0; c < 41; c++) begin
            if (done) nd++;
            if (c == 3)  check("loop_led_e0", led_o, 1);
            if (c == 5)  check("loop_step_c5", step_o, 0);
            if (c == 15) check("loop_step_c15", step_o, 1);
            if (c == 25) check("loop_step_c25", step_o, 0);
            if (c == 35) check("loop_step_c35", step_o, 1);
            if (c < 40) @(negedge clk);
        end
        check("loop_no_done", nd, 0);
        check("loop_busy", busy, 1);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        check("stop_busy", busy, 0);
        check("stop_led", led_o, 0);
        check("stop_done", done, 0);
        check("stop_step", step_o, 0);
        @(negedge clk);
        check("stop_done_after", done, 0);

        // Zero duration behaves as one tick
        write_entry(3'd0, 1'b1, 8'd0, 1'b1);
        run_play(1'b0, 12, 1'b0, 0, 3'd0, 1'b0, 8'd0, 1'b0, nb, nl, nd, ms, fl);
        check("dur0_busy_cycles", nb, 5);
        check("dur0_led_cycles", nl, 4);
        check("dur0_done", nd, 1);

        // No last bit anywhere: runs to entry 7 and stops
        for (int i = 0; i < 8; i++) begin
            write_entry(3'(i), ~i[0], 8'd1, 1'b0);
        end
        run_play(1'b0, 50, 1'b0, 0, 3'd0, 1'b0, 8'd0, 1'b0, nb, nl, nd, ms, fl);
        check("full_busy_cycles", nb, 40);
        check("full_led_cycles", nl, 20);
        check("full_done", nd, 1);
        check("full_max_step", ms, 7);

        // Write during busy is ignored; rewrite after done applies
        write_entry(3'd0, 1'b1, 8'd2, 1'b0);
        write_entry(3'd1, 1'b0, 8'd3, 1'b1);
        run_play(1'b0, 30, 1'b1, 3, 3'd1, 1'b1, 8'd1, 1'b1, nb, nl, nd, ms, fl);
        check("wrbusy_busy_cycles", nb, 22);
        check("wrbusy_led_cycles", nl, 9);
        write_entry(3'd1, 1'b1, 8'd1, 1'b1);
        run_play(1'b0, 20, 1'b0, 0, 3'd0, 1'b0, 8'd0, 1'b0, nb, nl, nd, ms, fl);
        check("rewr_busy_cycles", nb, 14);
        check("rewr_led_cycles", nl, 13);
        check("rewr_done", nd, 1);

        // start with stop in IDLE
        start = 1'b1; stop = 1'b1;
        @(negedge clk);
        start = 1'b0; stop = 1'b0;
        check("startstop_busy", busy, 0);
        @(negedge clk);
        check("startstop_busy2", busy, 0);

        // Reset mid-COUNT, then replay from retained table
        start = 1'b1; loop = 1'b1;
        @(negedge clk);
        start = 1'b0; loop = 1'b0;
        repeat (4) @(negedge clk);
        check("prerst_led", led_o, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_busy", busy, 0);
        check("midrst_led", led_o, 0);
        check("midrst_done", done, 0);
        check("midrst_step", step_o, 0);
        run_play(1'b0, 20, 1'b0, 0, 3'd0, 1'b0, 8'd0, 1'b0, nb, nl, nd, ms, fl);
        check("replay_busy_cycles", nb, 14);
        check("replay_led_cycles", nl, 13);
        check("replay_done", nd, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_blink_sequencer
`default_nettype wire
